// File: rtl/flag_unit.sv
// flag_unit: architectural flag register, same-cycle flag forwarding for
// conditional jump resolution, and a small LIFO of saved flag words for
// call/return.
module flag_unit #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned PTR_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       alu_flags,
  input  logic             alu_carry,
  input  logic             flag_wr_en,
  input  logic             cond_valid,
  input  logic [2:0]       cond_sel,
  input  logic             cond_jt,
  input  logic             flag_push,
  input  logic             flag_pop,
  output logic [5:0]       flags_q,
  output logic             branch_taken,
  output logic [PTR_W-1:0] stack_depth,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int unsigned FLAG_W = 6;
  localparam int unsigned IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] eff_flags;
  logic [PTR_W-1:0]  depth_q, depth_d;
  logic              err_q, err_d;
  logic              full, empty;
  logic              push_ok, pop_ok, err_set;
  logic              cond_bit;
  logic [IDX_W-1:0]  wr_idx, top_idx;

  // Status decode from the registered depth
  assign full        = (depth_q == PTR_W'(STACK_DEPTH));
  assign empty       = (depth_q == '0);
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_depth = depth_q;
  assign stack_err   = err_q;

  // Push/pop qualification; simultaneous push and pop is treated as a conflict
  assign push_ok = flag_push & ~flag_pop & ~full;
  assign pop_ok  = flag_pop & ~flag_push & ~empty;
  assign err_set = (flag_push & flag_pop)
                 | (flag_push & ~flag_pop & full)
                 | (flag_pop & ~flag_push & empty);

  assign wr_idx  = IDX_W'(depth_q);
  assign top_idx = IDX_W'(depth_q - PTR_W'(1));

  // Effective flags: an EX-stage write is visible in the same cycle
  assign eff_flags = flag_wr_en ? {alu_carry, alu_flags} : flags_q;

  // Condition select and jump resolution
  always_comb begin
    cond_bit = 1'b0;
    case (cond_sel)
      3'd0:    cond_bit = eff_flags[0];
      3'd1:    cond_bit = eff_flags[1];
      3'd2:    cond_bit = eff_flags[2];
      3'd3:    cond_bit = eff_flags[3];
      3'd4:    cond_bit = eff_flags[4];
      3'd5:    cond_bit = eff_flags[5];
      3'd6:    cond_bit = 1'b1;
      default: cond_bit = 1'b0;
    endcase
    branch_taken = cond_valid & (cond_jt ? cond_bit : ~cond_bit);
  end

  // Next-state for flag register, depth and sticky error
  always_comb begin
    flags_d = flags_q;
    depth_d = depth_q;
    err_d   = err_q | err_set;
    if (pop_ok) begin
      flags_d = stack_q[top_idx];
      depth_d = depth_q - PTR_W'(1);
    end else if (flag_wr_en) begin
      flags_d = {alu_carry, alu_flags};
    end
    if (push_ok) begin
      depth_d = depth_q + PTR_W'(1);
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      stack_q[wr_idx] <= eff_flags;
    end
  end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Consumer end of the ALU result/flag interface.
- Captures the 5 ALU flags plus the carry (alu_res[32]) into an architectural flag register.
- Resolves conditional jumps in decode, forwarding flags written in the same cycle.
- Keeps a small LIFO of saved flag words so call/return can preserve and restore condition state.

Parameters:
- STACK_DEPTH, 4, number of saved flag words (power of 2, 2..16)
- PTR_W, 3, width of depth counter; must satisfy 2**PTR_W > STACK_DEPTH

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- alu_flags  in  5  ALU flags: [0] zero, [1] true, [2] neg, [3] overflow, [4] negzero
- alu_carry  in  1  ALU carry, alu_res[32]
- flag_wr_en  in  1  EX-stage instruction updates flags this cycle
- cond_valid  in  1  ID-stage conditional jump present
- cond_sel  in  3  condition: 0 zero, 1 true, 2 neg, 3 overflow, 4 negzero, 5 carry, 6 always, 7 never
- cond_jt  in  1  1 = jump if condition true; 0 = jump if condition false
- flag_push  in  1  save the current effective flags (call)
- flag_pop  in  1  restore flags from the stack (return)
- flags_q  out  6  flag register {carry, negzero, overflow, neg, true, zero}
- branch_taken  out  1  conditional jump resolved taken (combinational)
- stack_depth  out  PTR_W  number of valid saved entries
- stack_full  out  1  stack_depth == STACK_DEPTH
- stack_empty  out  1  stack_depth == 0
- stack_err  out  1  sticky overflow/underflow/conflict error

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high.
- Reset values: flags_q=0, stack_depth=0, stack_err=0. Stack contents are don't-care.
  - Therefore stack_empty=1, stack_full=0 after reset.
- rst has priority over all other inputs, including mid push/pop.
- eff_flags = flag_wr_en ? {alu_carry, alu_flags} : flags_q. This forwarding is combinational, zero latency.
- branch_taken = cond_valid & (cond_jt ? c : ~c), where c = eff_flags bit selected by cond_sel.
  - cond_sel 6: c=1. cond_sel 7: c=0.
  - cond_valid=0 forces branch_taken=0.
- Flag register update, priority highest first at each clk edge:
  1. rst
  2. valid pop (not empty, no push): flags_q <= stack[top]
  3. flag_wr_en: flags_q <= {alu_carry, alu_flags}
  4. hold
- Push, when flag_push=1, flag_pop=0, not full:
  - stack[depth] <= eff_flags (includes a same-cycle EX write).
  - depth+1.
- Pop, when flag_pop=1, flag_push=0, not empty: depth-1.
  - A flag_wr_en in the same cycle is discarded.
- Push when full: stack and depth unchanged, stack_err <= 1. flags_q is still updated by flag_wr_en.
- Pop when empty: flags_q, depth unchanged, stack_err <= 1. flag_wr_en still applies.
- Push and pop in the same cycle: stack and depth unchanged, stack_err <= 1. flag_wr_en still applies.
- stack_err clears only on rst.
- flags_q changes only on clk edges. stack_full/stack_empty are decoded from the registered depth.
- No wrap-around: depth saturates at 0 and STACK_DEPTH.

Test Plan:
- Reset, then flag_wr_en=1, alu_flags=5'b00100, alu_carry=1 → next cycle flags_q=6'b100100; hold with wr_en=0 for 3 cycles → unchanged.
- Forwarding: flags_q=0; same cycle flag_wr_en=1, alu_flags=5'b00001, cond_valid=1, cond_sel=0, cond_jt=1 → branch_taken=1 that cycle. Same with cond_jt=0 → 0. cond_sel=7 → 0 for any flags.
- Carry select: flags_q=6'b100000, cond_sel=5, cond_jt=1 → taken=1. cond_sel=6, cond_jt=0 → taken=0.
- Stack round trip: push 4 distinct flag words (6'h01, 6'h02, 6'h04, 6'h08) → depth=4, full=1; 5th push → err=1, depth stays 4; 4 pops → flags_q sequence 08, 04, 02, 01, empty=1.
- Pop on empty with flag_wr_en=1, alu_flags=5'b00010 → err=1, depth=0, flags_q=6'b000010.
- Push+pop same cycle at depth 2 → depth 2, err=1. Assert rst mid-sequence → flags_q=0, depth=0, err=0 next cycle.
